// File: rtl/tse_mac_init_ctrl.sv
// Triple-speed Ethernet MAC configuration sequencer: resets, programs and
// verifies the MAC over Avalon-MM, then polls PHY BMSR for link state.
module tse_mac_init_ctrl #(
    parameter logic [47:0] MAC_ADDR    = 48'h001C_2317_4ACB,
    parameter logic [4:0]  PHY_ADDR    = 5'd0,
    parameter int          FRM_LEN     = 1518,
    parameter int          TX_IPG      = 12,
    parameter int          POLL_CYCLES = 2_500_000,
    parameter int          WAIT_TMO    = 1024,
    parameter int          RST_POLLS   = 16
) (
    input  logic        clk_25m_i,
    input  logic        srst_i,
    input  logic        start_i,
    output logic [7:0]  avm_address_o,
    output logic        avm_write_o,
    output logic        avm_read_o,
    output logic [31:0] avm_writedata_o,
    input  logic [31:0] avm_readdata_i,
    input  logic        avm_waitrequest_i,
    output logic        busy_o,
    output logic        init_done_o,
    output logic        link_up_o,
    output logic        error_o,
    output logic [1:0]  err_code_o
);

    localparam int PW = $clog2(POLL_CYCLES + 1);
    localparam int WW = $clog2(WAIT_TMO + 1);
    localparam int RW = $clog2(RST_POLLS + 1);

    localparam logic [PW-1:0] POLL_MAX = PW'(POLL_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(WAIT_TMO - 1);
    localparam logic [RW-1:0] RST_MAX  = RW'(RST_POLLS - 1);

    // MAC stores the first wire byte in the low byte of mac_0
    localparam logic [31:0] MAC_0 = {MAC_ADDR[23:16], MAC_ADDR[31:24],
                                     MAC_ADDR[39:32], MAC_ADDR[47:40]};
    localparam logic [31:0] MAC_1 = {16'h0, MAC_ADDR[7:0], MAC_ADDR[15:8]};

    localparam logic [3:0] ST_RST_POLL = 4'd2;
    localparam logic [3:0] ST_VERIFY   = 4'd8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_DONE,
        S_POLL,
        S_ERROR
    } state_t;

    state_t        state, state_n;
    logic [3:0]    step, step_n;
    logic [RW-1:0] rst_cnt, rst_cnt_n;
    logic [WW-1:0] wait_cnt, wait_cnt_n;
    logic [PW-1:0] poll_cnt, poll_cnt_n;
    logic          link_up, link_up_n;
    logic [1:0]    err_code, err_code_n;

    logic        rd_s, wr_s;
    logic [7:0]  addr_s;
    logic [31:0] wdata_s;
    logic        active, xfer_done, timeout;
    logic        rd_unused;

    assign rd_unused = ^{avm_readdata_i[31:14], avm_readdata_i[12:5]};

    always_comb begin
        rd_s    = 1'b0;
        wr_s    = 1'b0;
        addr_s  = 8'h00;
        wdata_s = 32'h0;
        if (state == S_INIT) begin
            unique case (step)
                4'd0: begin wr_s = 1'b1; addr_s = 8'h0F; wdata_s = {27'h0, PHY_ADDR}; end
                4'd1: begin wr_s = 1'b1; addr_s = 8'h02; wdata_s = 32'h0000_2000; end
                4'd2: begin rd_s = 1'b1; addr_s = 8'h02; end
                4'd3: begin wr_s = 1'b1; addr_s = 8'h03; wdata_s = MAC_0; end
                4'd4: begin wr_s = 1'b1; addr_s = 8'h04; wdata_s = MAC_1; end
                4'd5: begin wr_s = 1'b1; addr_s = 8'h05; wdata_s = 32'(FRM_LEN); end
                4'd6: begin wr_s = 1'b1; addr_s = 8'h17; wdata_s = 32'(TX_IPG); end
                4'd7: begin wr_s = 1'b1; addr_s = 8'h02; wdata_s = 32'h0000_001B; end
                4'd8: begin rd_s = 1'b1; addr_s = 8'h02; end
                default: ;
            endcase
        end else if (state == S_POLL) begin
            rd_s   = 1'b1;
            addr_s = 8'h81;
        end
    end

    assign active    = rd_s | wr_s;
    assign xfer_done = active & ~avm_waitrequest_i;
    assign timeout   = active & avm_waitrequest_i & (wait_cnt == WAIT_MAX);

    always_comb begin
        state_n    = state;
        step_n     = step;
        rst_cnt_n  = rst_cnt;
        poll_cnt_n = poll_cnt;
        link_up_n  = link_up;
        err_code_n = err_code;
        wait_cnt_n = '0;
        if (active && avm_waitrequest_i && wait_cnt != WAIT_MAX)
            wait_cnt_n = wait_cnt + WW'(1);

        unique case (state)
            S_IDLE: begin
                state_n   = S_INIT;
                step_n    = 4'd0;
                rst_cnt_n = '0;
            end
            S_INIT: begin
                if (timeout) begin
                    state_n    = S_ERROR;
                    err_code_n = 2'd1;
                end else if (xfer_done) begin
                    if (step == ST_RST_POLL) begin
                        if (!avm_readdata_i[13]) begin
                            step_n = step + 4'd1;
                        end else if (rst_cnt == RST_MAX) begin
                            state_n    = S_ERROR;
                            err_code_n = 2'd2;
                        end else begin
                            rst_cnt_n = rst_cnt + RW'(1);
                        end
                    end else if (step == ST_VERIFY) begin
                        if (avm_readdata_i[4:0] == 5'h1B) begin
                            state_n    = S_DONE;
                            poll_cnt_n = '0;
                        end else begin
                            state_n    = S_ERROR;
                            err_code_n = 2'd3;
                        end
                    end else begin
                        step_n = step + 4'd1;
                    end
                end
            end
            S_DONE: begin
                if (start_i) begin
                    state_n    = S_INIT;
                    step_n     = 4'd0;
                    rst_cnt_n  = '0;
                    link_up_n  = 1'b0;
                    err_code_n = 2'd0;
                end else if (poll_cnt == POLL_MAX) begin
                    state_n    = S_POLL;
                    poll_cnt_n = '0;
                end else begin
                    poll_cnt_n = poll_cnt + PW'(1);
                end
            end
            S_POLL: begin
                // interval keeps running during the read so polls stay periodic
                if (poll_cnt != POLL_MAX)
                    poll_cnt_n = poll_cnt + PW'(1);
                if (timeout) begin
                    state_n    = S_ERROR;
                    err_code_n = 2'd1;
                end else if (xfer_done) begin
                    state_n   = S_DONE;
                    link_up_n = avm_readdata_i[2];
                end
            end
            S_ERROR: begin
                if (start_i) begin
                    state_n    = S_INIT;
                    step_n     = 4'd0;
                    rst_cnt_n  = '0;
                    err_code_n = 2'd0;
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (state_n == S_ERROR)
            link_up_n = 1'b0;
    end

    always_ff @(posedge clk_25m_i) begin
        if (srst_i) begin
            state    <= S_IDLE;
            step     <= 4'd0;
            rst_cnt  <= '0;
            wait_cnt <= '0;
            poll_cnt <= '0;
            link_up  <= 1'b0;
            err_code <= 2'd0;
        end else begin
            state    <= state_n;
            step     <= step_n;
            rst_cnt  <= rst_cnt_n;
            wait_cnt <= wait_cnt_n;
            poll_cnt <= poll_cnt_n;
            link_up  <= link_up_n;
            err_code <= err_code_n;
        end
    end

    assign avm_address_o   = addr_s;
    assign avm_write_o     = wr_s;
    assign avm_read_o      = rd_s;
    assign avm_writedata_o = wdata_s;
    assign busy_o          = (state == S_INIT);
    assign init_done_o     = (state == S_DONE) || (state == S_POLL);
    assign error_o         = (state == S_ERROR);
    assign link_up_o       = link_up;
    assign err_code_o      = err_code;

endmodule
